multicycle_ctrl: RTL

Control FSM for the multi-cycle MIPS-subset CPU. It sequences the shared datapath (PC, IR, register file, single ALU, unified memory, immediate extender) through fetch/decode/execute/memory/writeback. It selects sign or zero extension of the 16-bit immediate per opcode. It stalls on a memory ready handshake.

---
 rtl/multicycle_ctrl_pkg.sv | 65 ++++++
 rtl/multicycle_ctrl_out_decode.sv | 81 ++++++++
 rtl/multicycle_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control FSM: opcodes,
// state enum, ALU/mux select encodings and the control-output bundle.
package multicycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC_R  = 4'd6,
        S_ALUWB_R = 4'd7,
        S_EXEC_I  = 4'd8,
        S_ALUWB_I = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_FUNCT = 3'b010,
        ALU_OR    = 3'b011,
        ALU_SLT   = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } src_b_e;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        src_b_e     alu_src_b;
        alu_op_e    alu_op;
        logic       ext_zero;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_out_decode.sv
// Combinational state/opcode -> datapath control map. MC_CTRL_JUMP_EN adds
// the JUMP state decode (pc_src = jump target).
import multicycle_ctrl_pkg::*;

module mc_out_decode (
    input  state_e     state_i,
    input  logic [5:0] op_i,
    input  logic       mem_ready_i,
    input  logic       run_i,
    output ctrl_t      ctrl_o
);

    ctrl_t c;

    always_comb begin
        c = '0;
        case (state_i)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                // IR and PC only latch in the cycle the instruction word arrives
                c.ir_write  = mem_ready_i;
                c.pc_write  = mem_ready_i;
            end
            S_DECODE:  c.alu_src_b = SRCB_IMM_SH2;
            S_MEMADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            S_ALUWB_R: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                case (op_i)
                    OP_SLTI: c.alu_op = ALU_SLT;
                    OP_ORI: begin
                        c.alu_op   = ALU_OR;
                        c.ext_zero = 1'b1;
                    end
                    default: c.alu_op = ALU_ADD;
                endcase
            end
            S_ALUWB_I: c.reg_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_src        = PCSRC_ALUOUT;
            end
`ifdef MC_CTRL_JUMP_EN
            S_JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = PCSRC_JUMP;
            end
`endif
            default: ;
        endcase
        // Hold every strobe low while reset is asserted
        ctrl_o = run_i ? c : '0;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: state register, memory wait/timeout
// tracking and next-state logic. Define MC_CTRL_JUMP_EN to support j.
import multicycle_ctrl_pkg::*;

module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic [1:0] pc_src_o,
    output logic       ir_write_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_dst_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic       ext_zero_o,
    output logic       illegal_o,
    output logic       timeout_o,
    output logic [3:0] state_o
);

    localparam int CW   = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam int WLIM = (MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0;

    state_e        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          timeout_q, timeout_d;
    logic          illegal_q, illegal_d;
    logic          req_st, wait_hit;
    ctrl_t         ctrl;

    // funct and zero are consumed by the ALU control / PC write gating downstream
    logic unused_ins;
    assign unused_ins = ^{funct_i, zero_i};

    assign req_st   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign wait_hit = (MEM_WAIT_MAX != 0) && (wait_q == CW'(WLIM));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW:              state_d = S_MEMADDR;
                    OP_RTYPE:                  state_d = S_EXEC_R;
                    OP_ADDI, OP_SLTI, OP_ORI:  state_d = S_EXEC_I;
                    OP_BEQ:                    state_d = S_BRANCH;
`ifdef MC_CTRL_JUMP_EN
                    OP_J:                      state_d = S_JUMP;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADDR: state_d = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWR:   if (mem_ready_i) state_d = S_FETCH;
            S_EXEC_R:  state_d = S_ALUWB_R;
            S_EXEC_I:  state_d = S_ALUWB_I;
            default:   state_d = S_FETCH;
        endcase
        // Abandon a stalled access after MEM_WAIT_MAX idle cycles and refetch
        if (req_st) begin
            if (mem_ready_i) begin
                wait_d = '0;
            end else if (wait_hit) begin
                wait_d    = '0;
                timeout_d = 1'b1;
                state_d   = S_FETCH;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    mc_out_decode u_dec (
        .state_i     (state_q),
        .op_i        (op_i),
        .mem_ready_i (mem_ready_i),
        .run_i       (rst_i),
        .ctrl_o      (ctrl)
    );

    assign pc_write_o      = ctrl.pc_write;
    assign pc_write_cond_o = ctrl.pc_write_cond;
    assign pc_src_o        = ctrl.pc_src;
    assign ir_write_o      = ctrl.ir_write;
    assign i_or_d_o        = ctrl.i_or_d;
    assign mem_read_o      = ctrl.mem_read;
    assign mem_write_o     = ctrl.mem_write;
    assign mem_to_reg_o    = ctrl.mem_to_reg;
    assign reg_dst_o       = ctrl.reg_dst;
    assign reg_write_o     = ctrl.reg_write;
    assign alu_src_a_o     = ctrl.alu_src_a;
    assign alu_src_b_o     = ctrl.alu_src_b;
    assign alu_op_o        = ctrl.alu_op;
    assign ext_zero_o      = ctrl.ext_zero;
    assign illegal_o       = illegal_q;
    assign timeout_o       = timeout_q;
    assign state_o         = state_q;

endmodule
